// File: rtl/bcd_calc_sequencer.sv
// bcd_calc_sequencer
//
// Keypad front end for a 4-digit BCD add/subtract accumulator.
// - Collects decimal digits into an entry register.
// - Issues single-cycle add/sub commands with a stable operand.
// - Waits for the accumulator's carry/borrow chain to settle.
// - Implements clear-all by applying the negated accumulator value.
// - Selects what the 7-segment display shows.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous reset, active low
//   key_valid      one-cycle key strobe
//   key_code       0-9 digit, 10 add, 11 sub, 12 clear-entry,
//                  13 clear-all, 14-15 ignored
//   acc_1..acc_4   accumulator BCD digits (low..high)
//   acc_negative   accumulator sign
//   operand_1..4   registered operand to the accumulator (low..high)
//   do_add/do_sub  registered single-cycle command pulses
//   disp_1..disp_4 displayed digits (low..high)
//   disp_neg       displayed sign
//   busy           high while a command is in flight
//   key_dropped    one-cycle pulse after a rejected key
module bcd_calc_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] acc_1,
    input  logic [3:0] acc_2,
    input  logic [3:0] acc_3,
    input  logic [3:0] acc_4,
    input  logic       acc_negative,
    output logic [3:0] operand_1,
    output logic [3:0] operand_2,
    output logic [3:0] operand_3,
    output logic [3:0] operand_4,
    output logic       do_add,
    output logic       do_sub,
    output logic [3:0] disp_1,
    output logic [3:0] disp_2,
    output logic [3:0] disp_3,
    output logic [3:0] disp_4,
    output logic       disp_neg,
    output logic       busy,
    output logic       key_dropped
);

    // The settle counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        CLR_ISSUE,
        CLR_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   entry_q, entry_d;
    logic [2:0]    count_q, count_d;
    logic          show_entry_q, show_entry_d;
    logic [15:0]   operand_q, operand_d;
    logic          do_add_q, do_add_d;
    logic          do_sub_q, do_sub_d;
    logic [CW-1:0] settle_q, settle_d;
    logic          key_dropped_q, key_dropped_d;

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            entry_q       <= '0;
            count_q       <= '0;
            show_entry_q  <= 1'b1;
            operand_q     <= '0;
            do_add_q      <= 1'b0;
            do_sub_q      <= 1'b0;
            settle_q      <= '0;
            key_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            count_q       <= count_d;
            show_entry_q  <= show_entry_d;
            operand_q     <= operand_d;
            do_add_q      <= do_add_d;
            do_sub_q      <= do_sub_d;
            settle_q      <= settle_d;
            key_dropped_q <= key_dropped_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        count_d       = count_q;
        show_entry_d  = show_entry_q;
        operand_d     = operand_q;
        do_add_d      = 1'b0;
        do_sub_d      = 1'b0;
        settle_d      = settle_q;
        key_dropped_d = 1'b0;

        // Outside IDLE every meaningful key is rejected; 14-15 never count.
        if (state_q != IDLE && key_valid && key_code <= 4'd13) begin
            key_dropped_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    case (key_code)
                        4'd10: begin
                            operand_d = entry_q;
                            do_add_d  = 1'b1;
                            state_d   = ISSUE;
                        end
                        4'd11: begin
                            operand_d = entry_q;
                            do_sub_d  = 1'b1;
                            state_d   = ISSUE;
                        end
                        4'd12: begin
                            entry_d      = '0;
                            count_d      = '0;
                            show_entry_d = 1'b1;
                        end
                        4'd13: begin
                            // Cancel the accumulator with a single opposing command.
                            operand_d = {acc_4, acc_3, acc_2, acc_1};
                            do_add_d  = acc_negative;
                            do_sub_d  = ~acc_negative;
                            state_d   = CLR_ISSUE;
                        end
                        default: begin
                            if (key_code <= 4'd9) begin
                                if (count_q == 3'd4) begin
                                    key_dropped_d = 1'b1;
                                end else begin
                                    entry_d      = {entry_q[11:0], key_code};
                                    show_entry_d = 1'b1;
                                    // Leading zeros do not consume a digit position.
                                    if (!(key_code == 4'd0 && count_q == 3'd0)) begin
                                        count_d = count_q + 3'd1;
                                    end
                                end
                            end
                        end
                    endcase
                end
            end
            ISSUE: begin
                state_d  = SETTLE;
                settle_d = SETTLE_INIT;
            end
            CLR_ISSUE: begin
                state_d  = CLR_SETTLE;
                settle_d = SETTLE_INIT;
            end
            SETTLE, CLR_SETTLE: begin
                if (settle_q == '0) begin
                    entry_d      = '0;
                    count_d      = '0;
                    show_entry_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: registered command/operand, combinational display select.
    always_comb begin
        operand_1   = operand_q[3:0];
        operand_2   = operand_q[7:4];
        operand_3   = operand_q[11:8];
        operand_4   = operand_q[15:12];
        do_add      = do_add_q;
        do_sub      = do_sub_q;
        key_dropped = key_dropped_q;
        busy        = (state_q != IDLE);
        if (show_entry_q) begin
            disp_1   = entry_q[3:0];
            disp_2   = entry_q[7:4];
            disp_3   = entry_q[11:8];
            disp_4   = entry_q[15:12];
            disp_neg = 1'b0;
        end else begin
            disp_1   = acc_1;
            disp_2   = acc_2;
            disp_3   = acc_3;
            disp_4   = acc_4;
            disp_neg = acc_negative;
        end
    end

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Testbench for bcd_calc_sequencer.
// A behavioural accumulator sits on the command outputs. A reference model,
// built from integers, predicts display, operand and control outputs.
module tb_bcd_calc_sequencer;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] acc_1, acc_2, acc_3, acc_4;
    logic       acc_negative;
    logic [3:0] operand_1, operand_2, operand_3, operand_4;
    logic       do_add, do_sub;
    logic [3:0] disp_1, disp_2, disp_3, disp_4;
    logic       disp_neg, busy, key_dropped;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural accumulator driven by the DUT's commands.
    int agg_value = 0;

    // Reference model state.
    int m_entry, m_count, m_busy, m_acc, m_oper;
    bit m_show, m_exp_add, m_exp_sub, m_exp_drop;

    bcd_calc_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .acc_1(acc_1), .acc_2(acc_2), .acc_3(acc_3), .acc_4(acc_4),
        .acc_negative(acc_negative),
        .operand_1(operand_1), .operand_2(operand_2),
        .operand_3(operand_3), .operand_4(operand_4),
        .do_add(do_add), .do_sub(do_sub),
        .disp_1(disp_1), .disp_2(disp_2), .disp_3(disp_3), .disp_4(disp_4),
        .disp_neg(disp_neg), .busy(busy), .key_dropped(key_dropped)
    );

    always #5 clk = ~clk;

    function automatic int abs_i(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    always @(posedge clk) begin
        if (do_add) agg_value <= agg_value + from_bcd({operand_4, operand_3, operand_2, operand_1});
        else if (do_sub) agg_value <= agg_value - from_bcd({operand_4, operand_3, operand_2, operand_1});
    end

    always_comb begin
        {acc_4, acc_3, acc_2, acc_1} = to_bcd(abs_i(agg_value));
        acc_negative = (agg_value < 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_entry = 0; m_count = 0; m_busy = 0; m_oper = 0;
        m_show = 1'b1; m_exp_add = 1'b0; m_exp_sub = 1'b0; m_exp_drop = 1'b0;
    endtask

    // One clock edge of the reference behaviour for the key sampled there.
    task automatic modelStep(input bit v, input int c);
        if (m_exp_add) m_acc = m_acc + m_oper;
        if (m_exp_sub) m_acc = m_acc - m_oper;
        m_exp_add = 1'b0; m_exp_sub = 1'b0; m_exp_drop = 1'b0;
        if (m_busy > 0) begin
            if (v && c <= 13) m_exp_drop = 1'b1;
            m_busy--;
            if (m_busy == 0) begin
                m_entry = 0; m_count = 0; m_show = 1'b0;
            end
        end else if (v) begin
            if (c <= 9) begin
                if (m_count == 4) m_exp_drop = 1'b1;
                else begin
                    m_entry = m_entry * 10 + c;
                    if (!(c == 0 && m_count == 0)) m_count++;
                    m_show = 1'b1;
                end
            end else if (c == 10) begin
                m_oper = m_entry; m_exp_add = 1'b1; m_busy = S + 1;
            end else if (c == 11) begin
                m_oper = m_entry; m_exp_sub = 1'b1; m_busy = S + 1;
            end else if (c == 12) begin
                m_entry = 0; m_count = 0; m_show = 1'b1;
            end else if (c == 13) begin
                m_oper = abs_i(m_acc);
                if (m_acc < 0) m_exp_add = 1'b1; else m_exp_sub = 1'b1;
                m_busy = S + 1;
            end
        end
    endtask

    task automatic checkModel();
        logic [16:0] exp_disp;
        exp_disp = m_show ? {1'b0, to_bcd(m_entry)} : {m_acc < 0, to_bcd(abs_i(m_acc))};
        checkOutput("disp", 32'({disp_neg, disp_4, disp_3, disp_2, disp_1}), 32'(exp_disp));
        checkOutput("operand", 32'({operand_4, operand_3, operand_2, operand_1}), 32'(to_bcd(m_oper)));
        checkOutput("ctrl{add,sub,busy,drop}", 32'({do_add, do_sub, busy, key_dropped}),
                    32'({m_exp_add, m_exp_sub, m_busy > 0, m_exp_drop}));
    endtask

    // Called just after a falling edge; drives a key, steps the model, checks.
    task automatic applyStimulus(input bit v, input int c);
        key_valid = v;
        key_code  = 4'(c);
        @(posedge clk);
        modelStep(v, c);
        @(negedge clk);
        checkModel();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
    endtask

    initial begin
        int code;
        bit vld;
        reset = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        m_acc = 0;
        modelReset();
        repeat (2) @(negedge clk);
        checkModel();
        reset = 1'b1;

        // Digit entry with leading zeros and overflow drop.
        applyStimulus(1, 0); applyStimulus(1, 0); applyStimulus(1, 1);
        applyStimulus(1, 2); applyStimulus(1, 3); applyStimulus(1, 4);
        checkOutput("disp_1234", 32'({disp_neg, disp_4, disp_3, disp_2, disp_1}), 32'h01234);
        applyStimulus(1, 5);
        checkOutput("drop_on_5th", 32'(key_dropped), 32'd1);
        checkOutput("still_1234", 32'({disp_4, disp_3, disp_2, disp_1}), 32'h1234);

        // 95 + 7 = 102
        applyStimulus(1, 12); applyStimulus(1, 9); applyStimulus(1, 5);
        applyStimulus(1, 10);
        idleCycles(S + 1);
        applyStimulus(1, 7); applyStimulus(1, 10);
        idleCycles(S + 1);
        checkOutput("acc_0102", 32'({disp_neg, disp_4, disp_3, disp_2, disp_1}), 32'h00102);

        // 102 - 200 = -98
        applyStimulus(1, 2); applyStimulus(1, 0); applyStimulus(1, 0);
        applyStimulus(1, 11);
        idleCycles(S + 1);
        checkOutput("acc_neg0098", 32'({disp_neg, disp_4, disp_3, disp_2, disp_1}), 32'h10098);

        // Clear-all from a negative value
        applyStimulus(1, 13);
        checkOutput("clr_is_add", 32'({do_add, do_sub}), 32'b10);
        idleCycles(S + 1);
        checkOutput("acc_zero", 32'({disp_neg, disp_4, disp_3, disp_2, disp_1}), 32'h00000);

        // Keys while busy: four dropped, the fifth accepted.
        applyStimulus(1, 1); applyStimulus(1, 10);
        for (int i = 0; i < 5; i++) applyStimulus(1, 3);
        checkOutput("fifth_key_taken", 32'({disp_neg, disp_4, disp_3, disp_2, disp_1}), 32'h00003);
        idleCycles(2);

        // Reset during the command cycle.
        applyStimulus(1, 10);
        key_valid = 1'b0;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("do_add_cut", 32'(do_add), 32'd0);
        checkModel();
        @(posedge clk);
        @(negedge clk);
        checkModel();
        reset = 1'b1;
        applyStimulus(1, 7);
        checkOutput("digit_after_reset", 32'({disp_neg, disp_4, disp_3, disp_2, disp_1}), 32'h00007);

        // Randomized traffic, steering add/sub to stay within four digits.
        for (int i = 0; i < 1500; i++) begin
            vld  = ($urandom_range(0, 3) != 0);
            code = int'($urandom_range(0, 15));
            if (code == 10 && m_acc + m_entry > 9999) code = 11;
            if (code == 11 && m_acc - m_entry < -9999) code = 10;
            applyStimulus(vld, code);
        end
        idleCycles(S + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
